// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared state encoding and latency bounds for mul_arbiter
package mul_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;
endpackage

// File: rtl/mul_8bit.sv
// mul_8bit: combinational 8x8 unsigned multiplier built as a partial-product adder tree
module mul_8bit (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [15:0] pp [8];
   logic [15:0] s1 [4];
   logic [15:0] s2 [2];
   for (genvar i = 0; i < 8; i++) begin : g_pp
      assign pp[i] = b[i] ? 16'(a) << i : 16'd0;
   end
   for (genvar i = 0; i < 4; i++) begin : g_s1
      assign s1[i] = pp[2*i] + pp[2*i+1];
   end
   for (genvar i = 0; i < 2; i++) begin : g_s2
      assign s2[i] = s1[2*i] + s1[2*i+1];
   end
   assign p = s2[0] + s2[1];
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one multicycle 8x8 multiplier between two requesters
module mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_v,
   input  logic        req1_v,
   input  logic [7:0]  req0_x,
   input  logic [7:0]  req0_y,
   input  logic [7:0]  req1_x,
   input  logic [7:0]  req1_y,
   output logic        req0_rdy,
   output logic        req1_rdy,
   output logic        rsp0_v,
   output logic        rsp1_v,
   input  logic        rsp0_ack,
   input  logic        rsp1_ack,
   output logic [15:0] rsp_r,
   output logic        busy
);
   state_t      state, state_n;
   logic        ptr, own, g1, ack, take;
   logic [1:0]  cnt;
   logic [7:0]  xa, ya;
   logic [15:0] prod, rsp_q;
   mul_8bit u_mul (.a(xa), .b(ya), .p(prod));
   // outputs are masked during rst so they read as reset values before the state register clears
   always_comb begin
      g1       = req1_v & (~req0_v | ptr);
      take     = (state == IDLE) & (req0_v | req1_v);
      ack      = own ? rsp1_ack : rsp0_ack;
      req0_rdy = ~rst & (state == IDLE) & req0_v & ~g1;
      req1_rdy = ~rst & (state == IDLE) & g1;
      rsp0_v   = ~rst & (state == RESP) & ~own;
      rsp1_v   = ~rst & (state == RESP) & own;
      busy     = ~rst & (state != IDLE);
      rsp_r    = rst ? 16'd0 : rsp_q;
      state_n  = state == IDLE ? (take ? CALC : IDLE) :
                 state == CALC ? (cnt == 2'd0 ? RESP : CALC) :
                 state == RESP ? (ack ? IDLE : RESP) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 1'b0;
         own   <= 1'b0;
         cnt   <= 2'd0;
         xa    <= 8'd0;
         ya    <= 8'd0;
         rsp_q <= 16'd0;
      end else begin
         state <= state_n;
         if (take) begin
            xa  <= g1 ? req1_x : req0_x;
            ya  <= g1 ? req1_y : req0_y;
            own <= g1;
            cnt <= 2'(LAT - 1);
         end
         if (state == CALC) cnt <= cnt - 2'd1;
         if (state == CALC && cnt == 2'd0) rsp_q <= prod;
         if (state == RESP && ack) ptr <= ~own;
      end
   end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized bench checking LAT=1 and LAT=4 arbiters against a transaction-level model
module tb_mul_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        rv  [2][2];
   logic [7:0]  rx  [2][2];
   logic [7:0]  ry  [2][2];
   logic        ak  [2][2];
   logic        rdy [2][2];
   logic        sv  [2][2];
   logic        bz  [2];
   logic [15:0] rr  [2];
   bit          act [2], own [2], ptr [2], acc [2][2];
   int          st [2], done [2];
   int          lat [2] = '{1, 4};
   logic [15:0] prod [2], mrsp [2];
   int          cyc, nchk, nerr;
   always #5 clk = ~clk;
   mul_arbiter #(.LAT(1)) u_l1 (
      .clk(clk), .rst(rst),
      .req0_v(rv[0][0]), .req1_v(rv[0][1]),
      .req0_x(rx[0][0]), .req0_y(ry[0][0]), .req1_x(rx[0][1]), .req1_y(ry[0][1]),
      .req0_rdy(rdy[0][0]), .req1_rdy(rdy[0][1]),
      .rsp0_v(sv[0][0]), .rsp1_v(sv[0][1]),
      .rsp0_ack(ak[0][0]), .rsp1_ack(ak[0][1]),
      .rsp_r(rr[0]), .busy(bz[0])
   );
   mul_arbiter #(.LAT(4)) u_l4 (
      .clk(clk), .rst(rst),
      .req0_v(rv[1][0]), .req1_v(rv[1][1]),
      .req0_x(rx[1][0]), .req0_y(ry[1][0]), .req1_x(rx[1][1]), .req1_y(ry[1][1]),
      .req0_rdy(rdy[1][0]), .req1_rdy(rdy[1][1]),
      .rsp0_v(sv[1][0]), .rsp1_v(sv[1][1]),
      .rsp0_ack(ak[1][0]), .rsp1_ack(ak[1][1]),
      .rsp_r(rr[1]), .busy(bz[1])
   );
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask
   function automatic bit grant1(input int d);
      return rv[d][1] && (!rv[d][0] || ptr[d]);
   endfunction
   function automatic bit in_resp(input int d);
      return act[d] && cyc >= st[d] + lat[d] + 1;
   endfunction
   task automatic compare();
      for (int d = 0; d < 2; d++) begin
         bit free, g;
         free = !rst && !act[d];
         g    = grant1(d);
         check($sformatf("rdy0[L%0d]", lat[d]), 16'(rdy[d][0]), 16'(free && rv[d][0] && !g));
         check($sformatf("rdy1[L%0d]", lat[d]), 16'(rdy[d][1]), 16'(free && g));
         check($sformatf("rsp0_v[L%0d]", lat[d]), 16'(sv[d][0]), 16'(!rst && in_resp(d) && !own[d]));
         check($sformatf("rsp1_v[L%0d]", lat[d]), 16'(sv[d][1]), 16'(!rst && in_resp(d) && own[d]));
         check($sformatf("busy[L%0d]", lat[d]), 16'(bz[d]), 16'(!rst && act[d]));
         check($sformatf("rsp_r[L%0d]", lat[d]), rr[d], rst ? 16'd0 : mrsp[d]);
      end
   endtask
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         bit g;
         g = grant1(d);
         acc[d][0] = 1'b0;
         acc[d][1] = 1'b0;
         if (rst) begin
            act[d]  = 1'b0;
            ptr[d]  = 1'b0;
            own[d]  = 1'b0;
            mrsp[d] = 16'd0;
         end else begin
            if (act[d] && cyc == st[d] + lat[d]) mrsp[d] = prod[d];
            if (!act[d] && (rv[d][0] || rv[d][1])) begin
               act[d]    = 1'b1;
               own[d]    = g;
               st[d]     = cyc;
               prod[d]   = 16'(rx[d][int'(g)]) * 16'(ry[d][int'(g)]);
               acc[d][int'(g)] = 1'b1;
            end else if (in_resp(d) && ak[d][int'(own[d])]) begin
               act[d] = 1'b0;
               ptr[d] = !own[d];
               done[d]++;
            end
         end
      end
   endtask
   task automatic cycle();
      @(negedge clk);
      compare();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++)
         for (int j = 0; j < 2; j++)
            if (acc[d][j]) rv[d][j] = 1'b0;
   endtask
   task automatic drive(input int preq, input int pack, input bit fixed);
      for (int d = 0; d < 2; d++)
         for (int j = 0; j < 2; j++) begin
            if (!rv[d][j] && $urandom_range(99) < preq) begin
               rv[d][j] = 1'b1;
               rx[d][j] = fixed ? (j == 0 ? 8'hFF : 8'h02) : 8'($urandom);
               ry[d][j] = fixed ? (j == 0 ? 8'hFF : 8'h03) : 8'($urandom);
            end
            ak[d][j] = $urandom_range(99) < pack;
         end
   endtask
   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int j = 0; j < 2; j++) begin
            rv[d][j] = 1'b0;
            rx[d][j] = 8'd0;
            ry[d][j] = 8'd0;
            ak[d][j] = 1'b0;
         end
      repeat (3) cycle();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         drive(100, 100, 1'b1);
         cycle();
      end
      for (int i = 0; i < 2000; i++) begin
         drive(60, 40, 1'b0);
         rst = $urandom_range(199) == 0;
         cycle();
      end
      for (int i = 0; i < 400; i++) begin
         drive(70, 50, 1'b0);
         rst = act[1] && cyc == st[1] + 2;
         cycle();
      end
      rst = 1'b0;
      check("progress[L1]", 16'(done[0] > 20), 16'd1);
      check("progress[L4]", 16'(done[1] > 20), 16'd1);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
